// File: rtl/elevator_sched.sv
// Single-cabin elevator scheduler: direction-preserving sweep over the
// registered cabin/hall request vectors, with registered motor, door,
// floor and request-clear outputs.
module elevator_sched #(
   parameter int FLOORS        = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 20,
   parameter int DOOR_CYCLES   = 30
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [FLOORS-1:0]  active_in_levels,
   input  logic [FLOORS-2:0]  active_out_up_levels,
   input  logic [FLOORS-1:1]  active_out_down_levels,
   output logic [FLOORS-1:0]  inactivate_in_levels,
   output logic [FLOORS-2:0]  inactivate_out_up_levels,
   output logic [FLOORS-1:1]  inactivate_out_down_levels,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               motor_up,
   output logic               motor_down,
   output logic               door_open
);

   localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

   state_t             state_reg, state_next;
   dir_t               dir_reg, dir_next;
   logic [FLOOR_W-1:0] floor_reg, floor_next;
   logic [TW-1:0]      travel_reg, travel_next;
   logic [DW-1:0]      door_cnt_reg, door_cnt_next;
   logic               eval_reg, eval_next;
   logic               go;

   logic               motor_up_reg, motor_down_reg, door_reg;
   logic [FLOORS-1:0]  inact_in_reg, inact_in_next;
   logic [FLOORS-2:0]  inact_up_reg, inact_up_next;
   logic [FLOORS-1:1]  inact_down_reg, inact_down_next;

   // Full-width request views; nonexistent hall bits read as 0.
   logic [FLOORS-1:0]  up_full, down_full, any_req;
   logic [FLOORS-1:0]  above_mask, below_mask, hit;
   logic               ahead_up, ahead_down, ahead_d, ahead_o;
   logic               in_cur, hall_d_cur, hall_o_cur;
   dir_t               dir_opp;

   genvar gi;
   generate
      for (gi = 0; gi < FLOORS; gi++) begin : g_floor
         if (gi < FLOORS - 1) begin : g_up
            assign up_full[gi] = active_out_up_levels[gi];
         end else begin : g_up_none
            assign up_full[gi] = 1'b0;
         end
         if (gi > 0) begin : g_down
            assign down_full[gi] = active_out_down_levels[gi];
         end else begin : g_down_none
            assign down_full[gi] = 1'b0;
         end
         assign any_req[gi]    = active_in_levels[gi] | up_full[gi] | down_full[gi];
         assign above_mask[gi] = (FLOOR_W'(gi) > floor_reg);
         assign below_mask[gi] = (FLOOR_W'(gi) < floor_reg);
         assign hit[gi]        = (FLOOR_W'(gi) == floor_next);
      end
   endgenerate

   assign ahead_up   = |(any_req & above_mask);
   assign ahead_down = |(any_req & below_mask);
   assign dir_opp    = (dir_reg == DIR_UP) ? DIR_DOWN : DIR_UP;
   assign ahead_d    = (dir_reg == DIR_UP) ? ahead_up : ahead_down;
   assign ahead_o    = (dir_reg == DIR_UP) ? ahead_down : ahead_up;
   assign in_cur     = active_in_levels[floor_reg];
   assign hall_d_cur = (dir_reg == DIR_UP) ? up_full[floor_reg] : down_full[floor_reg];
   assign hall_o_cur = (dir_reg == DIR_UP) ? down_full[floor_reg] : up_full[floor_reg];

   // Next-state: IDLE decision, travel/stop rule, door timer.
   always_comb begin
      state_next    = state_reg;
      dir_next      = dir_reg;
      floor_next    = floor_reg;
      travel_next   = travel_reg;
      door_cnt_next = door_cnt_reg;
      eval_next     = eval_reg;
      go            = 1'b0;
      case (state_reg)
         IDLE: begin
            travel_next   = '0;
            door_cnt_next = '0;
            eval_next     = 1'b0;
            if (in_cur | hall_d_cur) begin
               state_next = DOOR;
            end else if (ahead_d) begin
               state_next = (dir_reg == DIR_UP) ? MOVE_UP : MOVE_DOWN;
            end else if (hall_o_cur) begin
               state_next = DOOR;
               dir_next   = dir_opp;
            end else if (ahead_o) begin
               state_next = (dir_opp == DIR_UP) ? MOVE_UP : MOVE_DOWN;
               dir_next   = dir_opp;
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            go = 1'b1;
            // The cycle after arrival decides stop / continue / idle; a
            // continue is also the first counting cycle of the next leg.
            if (eval_reg) begin
               go = 1'b0;
               if (in_cur | hall_d_cur) begin
                  state_next = DOOR;
               end else if (!ahead_d && hall_o_cur) begin
                  state_next = DOOR;
                  dir_next   = dir_opp;
               end else if (ahead_d) begin
                  go = 1'b1;
               end else begin
                  state_next = IDLE;
               end
               if (!go) begin
                  eval_next     = 1'b0;
                  travel_next   = '0;
                  door_cnt_next = '0;
               end
            end
            if (go) begin
               if (travel_reg == TW'(TRAVEL_CYCLES - 1)) begin
                  floor_next  = (state_reg == MOVE_UP) ? floor_reg + FLOOR_W'(1)
                                                       : floor_reg - FLOOR_W'(1);
                  travel_next = '0;
                  eval_next   = 1'b1;
               end else begin
                  travel_next = travel_reg + TW'(1);
                  eval_next   = 1'b0;
               end
            end
         end
         DOOR: begin
            if (door_cnt_reg == DW'(DOOR_CYCLES - 1)) begin
               state_next    = IDLE;
               door_cnt_next = '0;
            end else begin
               door_cnt_next = door_cnt_reg + DW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Clear levels for the floor being served, in the served direction.
   always_comb begin
      inact_in_next   = '0;
      inact_up_next   = '0;
      inact_down_next = '0;
      if (state_next == DOOR) begin
         inact_in_next = hit;
         if (dir_next == DIR_UP) inact_up_next = hit[FLOORS-2:0];
         else                    inact_down_next = hit[FLOORS-1:1];
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         dir_reg        <= DIR_UP;
         floor_reg      <= '0;
         travel_reg     <= '0;
         door_cnt_reg   <= '0;
         eval_reg       <= 1'b0;
         motor_up_reg   <= 1'b0;
         motor_down_reg <= 1'b0;
         door_reg       <= 1'b0;
         inact_in_reg   <= '0;
         inact_up_reg   <= '0;
         inact_down_reg <= '0;
      end else begin
         state_reg      <= state_next;
         dir_reg        <= dir_next;
         floor_reg      <= floor_next;
         travel_reg     <= travel_next;
         door_cnt_reg   <= door_cnt_next;
         eval_reg       <= eval_next;
         motor_up_reg   <= (state_next == MOVE_UP);
         motor_down_reg <= (state_next == MOVE_DOWN);
         door_reg       <= (state_next == DOOR);
         inact_in_reg   <= inact_in_next;
         inact_up_reg   <= inact_up_next;
         inact_down_reg <= inact_down_next;
      end
   end

   assign current_floor              = floor_reg;
   assign motor_up                   = motor_up_reg;
   assign motor_down                 = motor_down_reg;
   assign door_open                  = door_reg;
   assign inactivate_in_levels       = inact_in_reg;
   assign inactivate_out_up_levels   = inact_up_reg;
   assign inactivate_out_down_levels = inact_down_reg;

endmodule

// File: tb/tb_elevator_sched.sv
// Directed bench for elevator_sched: door events are checked against a
// scoreboard of expected stops, plus per-cycle output invariants.
module tb_elevator_sched;

   localparam int FLOORS = 8;
   localparam int FW     = 3;
   localparam int TRAVEL = 4;
   localparam int DOORC  = 6;

   logic          clock;
   logic          reset;
   logic [7:0]    in_req;
   logic [6:0]    up_req;
   logic [7:1]    down_req;
   logic [7:0]    inact_in;
   logic [6:0]    inact_up;
   logic [7:1]    inact_down;
   logic [FW-1:0] floor;
   logic          mu, md, door;

   elevator_sched #(
      .FLOORS(FLOORS), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOORC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .active_in_levels(in_req),
      .active_out_up_levels(up_req),
      .active_out_down_levels(down_req),
      .inactivate_in_levels(inact_in),
      .inactivate_out_up_levels(inact_up),
      .inactivate_out_down_levels(inact_down),
      .current_floor(floor),
      .motor_up(mu),
      .motor_down(md),
      .door_open(door)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int fl;
      int ii;
      int iu;
      int id;
   } exp_t;

   exp_t sb[$];
   int   rise_log[$];
   int   floor_log[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc, mu_cnt, md_cnt, door_cnt;
   int   ii_cnt[8];
   logic door_prev = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int fl, input int ii, input int iu, input int id);
      exp_t e;
      e.fl = fl; e.ii = ii; e.iu = iu; e.id = id;
      sb.push_back(e);
   endtask

   task automatic clear_stats();
      cyc = 0; mu_cnt = 0; md_cnt = 0; door_cnt = 0;
      for (int i = 0; i < 8; i++) ii_cnt[i] = 0;
      rise_log.delete();
      floor_log.delete();
   endtask

   // One clock: sample after the edge, check invariants, score door events,
   // and drop any request whose clear level is seen.
   task automatic step();
      logic rst_edge, pmu, pmd;
      int   pf, efl;
      exp_t e;
      rst_edge = reset; pf = int'(floor); pmu = mu; pmd = md;
      @(posedge clock);
      #1;
      cyc++;
      chk("motor_excl", int'(mu & md), 0);
      chk("door_motor", int'(door & (mu | md)), 0);
      if (!door) chk("inact_idle", int'(|{inact_in, inact_up, inact_down}), 0);
      if (!rst_edge && int'(floor) != pf) begin
         efl = pmu ? pf + 1 : (pmd ? pf - 1 : pf);
         chk("floor_step", int'(floor), efl);
         floor_log.push_back(int'(floor));
      end
      mu_cnt += int'(mu);
      md_cnt += int'(md);
      door_cnt += int'(door);
      for (int i = 0; i < 8; i++) ii_cnt[i] += int'(inact_in[i]);
      if (door && !door_prev) begin
         rise_log.push_back(cyc);
         chk("sb_pending", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stop_floor", int'(floor), e.fl);
            chk("stop_inact_in", int'(inact_in), e.ii);
            chk("stop_inact_up", int'({1'b0, inact_up}), e.iu);
            chk("stop_inact_down", int'({inact_down, 1'b0}), e.id);
            $display("door opened at floor %0d (cycle %0d)", floor, cyc);
         end
      end
      door_prev = door;
      in_req   = in_req & ~inact_in;
      up_req   = up_req & ~inact_up;
      down_req = down_req & ~inact_down;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_req = '0; up_req = '0; down_req = '0;
      step();
      step();
      reset = 1'b0;
      sb.delete();
      clear_stats();
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (sb.size() == 0 && !door && !mu && !md &&
             in_req == '0 && up_req == '0 && down_req == '0) break;
      end
      chk({tag, "_drain"}, sb.size(), 0);
   endtask

   initial begin
      reset = 1'b0;
      in_req = '0; up_req = '0; down_req = '0;

      // Reset state.
      do_reset();
      chk("rst_floor", int'(floor), 0);
      chk("rst_motors", int'({mu, md}), 0);
      chk("rst_door", int'(door), 0);
      chk("rst_inact", int'(|{inact_in, inact_up, inact_down}), 0);

      // Cabin request three floors up.
      in_req[3] = 1'b1;
      push_exp(3, 8'h08, 8'h08, 0);
      wait_drain("t1", 200);
      chk("t1_mu_cycles", mu_cnt, 13);
      chk("t1_md_cycles", md_cnt, 0);
      chk("t1_door_cycles", door_cnt, DOORC);
      chk("t1_inact3_cycles", ii_cnt[3], DOORC);
      chk("t1_rises", rise_log.size(), 1);
      if (rise_log.size() == 1) chk("t1_latency", rise_log[0], 1 + 3 * TRAVEL + 1);
      chk("t1_floor_steps", floor_log.size(), 3);
      if (floor_log.size() == 3) begin
         chk("t1_f1", floor_log[0], 1);
         chk("t1_f2", floor_log[1], 2);
         chk("t1_f3", floor_log[2], 3);
      end
      chk("t1_end_floor", int'(floor), 3);

      // Hall up at 2 and hall down at 5 together; then last_dir is DOWN.
      do_reset();
      up_req[2] = 1'b1;
      down_req[5] = 1'b1;
      push_exp(2, 8'h04, 8'h04, 0);
      push_exp(5, 8'h20, 0, 8'h20);
      wait_drain("t2a", 300);
      in_req[1] = 1'b1;
      in_req[7] = 1'b1;
      push_exp(1, 8'h02, 0, 8'h02);
      push_exp(7, 8'h80, 0, 0);
      wait_drain("t2b", 400);
      chk("t2_end_floor", int'(floor), 7);

      // Cabin 6 plus hall down 4: pass 4, serve 6, return to 4.
      do_reset();
      in_req[6] = 1'b1;
      down_req[4] = 1'b1;
      push_exp(6, 8'h40, 8'h40, 0);
      push_exp(4, 8'h10, 0, 8'h10);
      wait_drain("t3", 300);
      chk("t3_mu_cycles", mu_cnt, 6 * TRAVEL + 1);
      chk("t3_md_cycles", md_cnt, 2 * TRAVEL + 1);
      chk("t3_end_floor", int'(floor), 4);

      // Request at the idle floor opens the door next cycle.
      do_reset();
      in_req[0] = 1'b1;
      push_exp(0, 8'h01, 8'h01, 0);
      wait_drain("t4", 100);
      chk("t4_rises", rise_log.size(), 1);
      if (rise_log.size() == 1) chk("t4_latency", rise_log[0], 1);
      chk("t4_motor_cycles", mu_cnt + md_cnt, 0);
      chk("t4_inact0_cycles", ii_cnt[0], DOORC);

      // Presses at the open door: served direction cleared, opposite reopens.
      do_reset();
      in_req[3] = 1'b1;
      push_exp(3, 8'h08, 8'h08, 0);
      for (int i = 0; i < 100; i++) begin
         step();
         if (door) break;
      end
      chk("t5_door_open", int'(door), 1);
      step();
      step();
      in_req[3] = 1'b1;
      up_req[3] = 1'b1;
      step();
      chk("t5_clear_in3", int'(inact_in[3]), 1);
      chk("t5_clear_up3", int'(inact_up[3]), 1);
      down_req[3] = 1'b1;
      push_exp(3, 8'h08, 0, 8'h08);
      step();
      chk("t5_down3_kept", int'(down_req[3]), 1);
      wait_drain("t5", 100);
      chk("t5_door_cycles", door_cnt, 2 * DOORC);
      chk("t5_rises", rise_log.size(), 2);
      if (rise_log.size() == 2) chk("t5_reopen_gap", rise_log[1] - rise_log[0], DOORC + 1);

      // Reset in the middle of travel between floors 2 and 3.
      do_reset();
      in_req[5] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (floor == 3'd2) break;
      end
      chk("t6_reached2", int'(floor), 2);
      step();
      step();
      chk("t6_moving", int'(mu), 1);
      reset = 1'b1;
      in_req = '0;
      step();
      chk("t6_floor", int'(floor), 0);
      chk("t6_motors", int'({mu, md}), 0);
      chk("t6_door", int'(door), 0);
      chk("t6_inact", int'(|{inact_in, inact_up, inact_down}), 0);
      reset = 1'b0;
      step();
      chk("t6_idle_floor", int'(floor), 0);
      chk("t6_idle_motors", int'({mu, md, door}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/elevator_sched.md
Name: elevator_sched

Overview:
- Single-cabin elevator scheduler that sequences the button-request register block.
- Consumes its registered in-cabin, hall-up and hall-down request vectors and runs a direction-preserving sweep: keep going while requests lie ahead, reverse when none remain.
- Drives motor up/down, door and current-floor outputs.
- Returns clear (inactivate) levels to the request register for every request served at the current floor.

Parameters:
FLOORS, 8, number of floors; floor 0 = bottom, FLOORS-1 = top
FLOOR_W, 3, width of current_floor; must satisfy 2**FLOOR_W >= FLOORS
TRAVEL_CYCLES, 20, clock cycles to travel one floor
DOOR_CYCLES, 30, clock cycles door stays open per stop

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- active_in_levels  in  FLOORS  cabin requests, bit f = floor f.
- active_out_up_levels  in  FLOORS-1  hall up calls, bits [FLOORS-2:0].
- active_out_down_levels  in  FLOORS-1  hall down calls, bits [FLOORS-1:1].
- inactivate_in_levels  out  FLOORS  clear cabin request.
- inactivate_out_up_levels  out  FLOORS-1  clear hall up, [FLOORS-2:0].
- inactivate_out_down_levels  out  FLOORS-1  clear hall down, [FLOORS-1:1].
- current_floor  out  FLOOR_W  cabin position.
- motor_up  out  1  cabin travelling up.
- motor_down  out  1  cabin travelling down.
- door_open  out  1  door open.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset, including mid-operation: state IDLE, last_dir = UP, current_floor = 0, travel/door counters = 0, all outputs 0.
- All outputs are registered. motor_up and motor_down are never both 1. door_open = 1 only when both motors = 0.
- Nonexistent hall bits (up at top, down at floor 0) read as 0.
- "Request at f" = in[f] | up[f] | down[f].
- "Ahead(d)" = any request strictly above current_floor for d=UP, strictly below for d=DOWN.
- hall[d][f] = up[f] for d=UP, down[f] for d=DOWN.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- IDLE decision, evaluated every IDLE cycle, first match wins; d = last_dir, o = opposite:
  1. in[cur] | hall[d][cur] -> DOOR, serve dir d.
  2. Ahead(d) -> MOVE_d.
  3. hall[o][cur] -> DOOR, last_dir <= o.
  4. Ahead(o) -> MOVE_o, last_dir <= o.
  5. Otherwise stay IDLE, outputs idle.
- MOVE_d:
  - Motor bit for d held high; travel counter counts 0..TRAVEL_CYCLES-1.
  - On the terminal count, current_floor steps ±1 and the counter clears.
  - The cycle after arrival evaluates the stop rule at the new floor f, using the request vectors of that cycle:
    - in[f] | hall[d][f], or (no Ahead(d) and hall[o][f]) -> DOOR; last_dir <= o in the latter case.
    - else Ahead(d) -> continue (counter restarts).
    - else -> IDLE.
  - Motor stays high through the evaluation cycle.
  - Floor counter never leaves 0..FLOORS-1; the ahead logic guarantees this, and the bench asserts it.
- DOOR:
  - Motors 0; door_open = 1 for exactly DOOR_CYCLES cycles, then -> IDLE.
  - Throughout DOOR, inactivate_in_levels[cur] and inactivate hall[last_dir][cur] are held at level 1; all other inactivate bits are 0.
  - A press at cur in the served direction or in-cabin during DOOR is therefore cleared immediately and does not extend the door time.
  - An opposite-direction hall call at cur is not cleared. It is picked up by IDLE rule 3 when no requests remain ahead.
- Simultaneous requests: priority is fixed by the IDLE rule order and the stop rule; no fairness counters.
- Latency: from IDLE with a request k floors away, the door opens after 1 + k*TRAVEL_CYCLES + 1 cycles.

Test Plan:
Bench parameters for all cases: FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6. The bench holds each request high until the matching inactivate bit is seen.
- Reset, then in[3]=1 -> motor_up high 12 travel cycles plus 1 evaluation cycle; current_floor steps 1,2,3; door_open high 6 cycles; inactivate_in_levels[3] high exactly those 6 cycles; then IDLE at floor 3.
- From floor 0: up[2]=1 and down[5]=1 together -> stops at 2 with inactivate_out_up_levels[2]; continues to 5 with inactivate_out_down_levels[5]; last_dir = DOWN afterwards.
- From floor 0: in[6]=1 and down[4]=1 -> passes floor 4 without stopping; door at 6; reverses with motor_down; stops at 4 clearing down[4].
- Idle at floor 0, in[0]=1 -> door_open the next cycle, no motor activity, inactivate_in_levels[0] high 6 cycles.
- During the door at floor 3 (served UP), press in[3] and up[3] -> both cleared, door still closes after 6 cycles. Press down[3] with no other requests -> door reopens (IDLE rule 3) with inactivate_out_down_levels[3].
- Reset asserted mid-travel between floors 2 and 3 -> the next cycle current_floor=0, motors 0, door_open 0, inactivate all 0.
